// File: rtl/bus_arbiter_pkg.sv
// Shared bus header: master count, master indices, active-low levels and grant decode.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int OWNER_W     = 2;
    localparam int DATA_W      = 32;
    localparam int HOLD_W      = 8;

    localparam int M_CPU_IF  = 0;
    localparam int M_CPU_MEM = 1;
    localparam int M_PERIPH  = 2;
    localparam int M_DMA     = 3;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef logic [OWNER_W-1:0] owner_t;

    // One-hot-low grant vector for a given owner.
    function automatic logic [NUM_MASTERS-1:0] grant_vec(input owner_t owner);
        logic [NUM_MASTERS-1:0] v;
        v        = {NUM_MASTERS{DISABLE_}};
        v[owner] = ENABLE_;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Combinational round-robin search: owner+1, owner+2, owner+3 (mod 4); the owner itself is never a candidate.
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
(
    input  owner_t                 owner,
    input  logic [NUM_MASTERS-1:0] req,
    output owner_t                 next_owner,
    output logic                   hit
);

    owner_t cand [1:NUM_MASTERS-1];

    genvar gi;
    generate
        for (gi = 1; gi < NUM_MASTERS; gi++) begin : g_cand
            assign cand[gi] = owner + owner_t'(gi);
        end
    endgenerate

    // Scan farthest-first so the nearest requester overwrites and wins.
    always_comb begin
        next_owner = owner;
        hit        = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
            if (req[cand[k]]) begin
                next_owner = cand[k];
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master shared-bus arbiter with parking, round-robin hand-over, hold-time pre-emption
// and a transfer tracker that pins ownership while a transfer is outstanding.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req_,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_as_,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]        m_grnt_,
    output logic [NUM_MASTERS-1:0]        m_rdy_,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic [DATA_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    input  logic                          s_rdy_,
    input  logic [DATA_W-1:0]             s_rd_data
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    owner_t                 owner_q, owner_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
    logic                   busy_q, busy_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    owner_t rr_owner;
    logic   rr_hit;
    logic   own_as_;
    logic   own_req_;
    logic   may_move;
    logic   want_move;

    logic [DATA_W-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

    bus_arbiter_rr u_rr (
        .owner      (owner_q),
        .req        (~m_req_),
        .next_owner (rr_owner),
        .hit        (rr_hit)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign addr_arr[gi]  = m_addr[gi*DATA_W +: DATA_W];
            assign wdata_arr[gi] = m_wr_data[gi*DATA_W +: DATA_W];
            assign m_rdy_[gi]    = (owner_q == owner_t'(gi)) ? s_rdy_ : DISABLE_;
        end
    endgenerate

    assign own_as_   = m_as_[owner_q];
    assign own_req_  = m_req_[owner_q];
    assign s_addr    = addr_arr[owner_q];
    assign s_wr_data = wdata_arr[owner_q];
    assign s_as_     = own_as_;
    assign s_rw      = m_rw[owner_q];
    assign m_rd_data = s_rd_data;
    assign m_grnt_   = grnt_q;

    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        hold_d  = hold_q;

        // Slave ready wins: an address strobe answered in the same cycle never marks busy.
        if (s_rdy_ == ENABLE_) begin
            busy_d = 1'b0;
        end else if (own_as_ == ENABLE_) begin
            busy_d = 1'b1;
        end

        may_move  = !busy_q && (own_as_ == DISABLE_);
        want_move = (own_req_ == DISABLE_) || (hold_q == HOLD_LIM);

        if (may_move && want_move && rr_hit) begin
            owner_d = rr_owner;
            hold_d  = '0;
        end else if (hold_q < HOLD_LIM) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        grnt_d = grant_vec(owner_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= owner_t'(M_CPU_IF);
            grnt_q  <= grant_vec(owner_t'(M_CPU_IF));
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios followed by random traffic, checked every cycle against a behavioural arbiter model.
module tb_bus_arbiter;

    localparam int HOLD = 4;

    logic         clk;
    logic         reset;
    logic [3:0]   m_req_;
    logic [127:0] m_addr;
    logic [3:0]   m_as_;
    logic [3:0]   m_rw;
    logic [127:0] m_wr_data;
    logic [3:0]   m_grnt_;
    logic [3:0]   m_rdy_;
    logic [31:0]  m_rd_data;
    logic [31:0]  s_addr;
    logic         s_as_;
    logic         s_rw;
    logic [31:0]  s_wr_data;
    logic         s_rdy_;
    logic [31:0]  s_rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int mo_owner = 0;
    int mo_hold  = 0;
    bit mo_busy  = 0;

    bus_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_grnt_   (m_grnt_),
        .m_rdy_    (m_rdy_),
        .m_rd_data (m_rd_data),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .s_rdy_    (s_rdy_),
        .s_rd_data (s_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // First requesting master found walking forward from the owner, or -1 if none.
    function automatic int rr_pick(input int own, input logic [3:0] req_n);
        for (int k = 1; k < 4; k++) begin
            if (req_n[(own + k) % 4] == 1'b0) return (own + k) % 4;
        end
        return -1;
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) begin
            m_addr[i*32 +: 32]    = $urandom;
            m_wr_data[i*32 +: 32] = $urandom;
        end
        m_rw      = 4'($urandom);
        s_rd_data = $urandom;
    endtask

    task automatic check_all();
        logic [3:0] exp_gnt;
        logic [3:0] exp_rdy;
        exp_gnt           = 4'hF;
        exp_gnt[mo_owner] = 1'b0;
        exp_rdy           = 4'hF;
        exp_rdy[mo_owner] = s_rdy_;
        check("grant",   32'(m_grnt_), 32'(exp_gnt));
        check("m_rdy",   32'(m_rdy_), 32'(exp_rdy));
        check("s_addr",  s_addr, m_addr[mo_owner*32 +: 32]);
        check("s_wdata", s_wr_data, m_wr_data[mo_owner*32 +: 32]);
        check("s_as",    32'(s_as_), 32'(m_as_[mo_owner]));
        check("s_rw",    32'(s_rw), 32'(m_rw[mo_owner]));
        check("rd_data", m_rd_data, s_rd_data);
        check("busy",    32'(dut.busy_q), 32'(mo_busy));
        check("hold",    32'(dut.hold_q), 32'(mo_hold));
    endtask

    // Advance one clock: predict from the inputs sampled at the edge, then compare.
    task automatic step();
        int n_owner;
        int n_hold;
        int pick;
        bit n_busy;
        if (reset) begin
            n_owner = 0;
            n_hold  = 0;
            n_busy  = 1'b0;
        end else begin
            pick   = rr_pick(mo_owner, m_req_);
            n_busy = mo_busy;
            if (s_rdy_ == 1'b0)             n_busy = 1'b0;
            else if (m_as_[mo_owner] == 1'b0) n_busy = 1'b1;
            if (!mo_busy && m_as_[mo_owner] && pick >= 0 &&
                (m_req_[mo_owner] || mo_hold == HOLD)) begin
                n_owner = pick;
                n_hold  = 0;
            end else begin
                n_owner = mo_owner;
                n_hold  = (mo_hold < HOLD) ? mo_hold + 1 : HOLD;
            end
        end
        @(posedge clk);
        #1;
        mo_owner = n_owner;
        mo_hold  = n_hold;
        mo_busy  = n_busy;
        cyc++;
        $display("cyc %0d rst=%b req_=%b as_=%b s_rdy_=%b -> grnt_=%b owner=%0d hold=%0d busy=%0d",
                 cyc, reset, m_req_, m_as_, s_rdy_, m_grnt_, mo_owner, mo_hold, mo_busy);
        check_all();
    endtask

    initial begin
        reset  = 1'b1;
        m_req_ = 4'hF;
        m_as_  = 4'hF;
        s_rdy_ = 1'b1;
        randomize_data();
        step();
        step();
        check("reset_grant", 32'(m_grnt_), 32'h0000_000E);
        check("reset_busy",  32'(dut.busy_q), 32'h0);
        check("reset_hold",  32'(dut.hold_q), 32'h0);
        reset = 1'b0;

        // Parking: no requests, master 0 keeps the bus.
        for (int i = 0; i < 6; i++) begin
            randomize_data();
            step();
            check("park_grant", 32'(m_grnt_), 32'h0000_000E);
            check("park_addr",  s_addr, m_addr[31:0]);
        end

        // Owner 0 releases with masters 1 and 2 requesting.
        m_req_ = 4'b1001;
        step();
        check("release_0to1", 32'(m_grnt_), 32'h0000_000D);

        // Master 1 releases with only 3 requesting, then 3 releases with 0 and 2 requesting.
        m_req_ = 4'b0111;
        step();
        check("release_1to3", 32'(m_grnt_), 32'h0000_0007);
        m_req_ = 4'b1010;
        step();
        check("wrap_3to0", 32'(m_grnt_), 32'h0000_000E);

        // Hold-time pre-emption: 0 keeps requesting, 2 waits.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_keep", 32'(m_grnt_), 32'h0000_000E);
        end
        step();
        check("preempt_grant", 32'(m_grnt_), 32'h0000_000B);
        check("preempt_hold",  32'(dut.hold_q), 32'h0);

        // Pre-emption blocked by an outstanding transfer until the cycle after slave ready.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        m_as_ = 4'b1110;
        step();
        check("xfer_busy", 32'(dut.busy_q), 32'h1);
        check("xfer_grant0", 32'(m_grnt_), 32'h0000_000E);
        step();
        step();
        check("xfer_grant2", 32'(m_grnt_), 32'h0000_000E);
        s_rdy_ = 1'b0;
        step();
        check("xfer_rdy_grant", 32'(m_grnt_), 32'h0000_000E);
        check("xfer_rdy_busy",  32'(dut.busy_q), 32'h0);
        m_as_  = 4'hF;
        s_rdy_ = 1'b1;
        step();
        check("xfer_done_grant", 32'(m_grnt_), 32'h0000_000B);

        // Reset while owner 2 is mid-transfer.
        m_as_ = 4'b1011;
        step();
        check("mid_busy", 32'(dut.busy_q), 32'h1);
        reset = 1'b1;
        step();
        check("mid_rst_grant", 32'(m_grnt_), 32'h0000_000E);
        check("mid_rst_rdy",   32'(m_rdy_), 32'h0000_000F);
        check("mid_rst_busy",  32'(dut.busy_q), 32'h0);
        reset = 1'b0;
        m_as_ = 4'hF;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(99) == 0);
            m_req_ = 4'($urandom);
            for (int j = 0; j < 4; j++) m_as_[j] = ($urandom_range(3) != 0);
            s_rdy_ = ($urandom_range(2) != 0);
            randomize_data();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, max consecutive grant cycles before the owner can be pre-empted; range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m_req_  input  4  per-master bus request, active-low; master 0 = CPU IF port, master 1 = CPU MEM port, masters 2-3 = peripherals/DMA.
REQ-005 m_addr  input  4x32  per-master word address, packed {m3,m2,m1,m0}.
REQ-006 m_as_  input  4  per-master address strobe, active-low.
REQ-007 m_rw  input  4  per-master direction: 1 = read, 0 = write.
REQ-008 m_wr_data  input  4x32  per-master write data, packed as m_addr.
REQ-009 m_grnt_  output  4  per-master grant, active-low, registered; one-hot-low.
REQ-010 m_rdy_  output  4  per-master ready, active-low; s_rdy_ routed to owner only, others held 1.
REQ-011 m_rd_data  output  32  s_rd_data broadcast to all masters.
REQ-012 s_addr / s_as_ / s_rw / s_wr_data  output  32/1/1/32  shared-bus signals muxed from the owner.
REQ-013 s_rdy_  input  1  slave ready, active-low.
REQ-014 s_rd_data  input  32  slave read data.

Function
REQ-015 Owner register (2 bits) SHALL identify exactly one master at all times; m_grnt_[i] SHALL be 0 iff owner==i.
REQ-016 Bus parking: with no requests, ownership SHALL remain unchanged.
REQ-017 Owner deasserting m_req_ (=1) SHALL trigger round-robin search owner+1, owner+2, owner+3 (mod 4) among masters with m_req_=0; first hit becomes owner next cycle; none found -> owner unchanged.
REQ-018 Grant change latency: new m_grnt_ visible exactly one cycle after the edge sampling the release.
REQ-019 Owner with m_req_ held 0 SHALL keep grant, subject to REQ-021.
REQ-020 Transfer tracker: busy SHALL set on edge where owner's m_as_=0 and s_rdy_=1; clear on edge where s_rdy_=0; as_=0 with s_rdy_=0 same cycle = single-cycle transfer, busy stays 0.
REQ-021 Hold counter (8 bits) SHALL increment each cycle owner is unchanged, saturating at HOLD_MAX, reset to 0 on any owner change; when counter==HOLD_MAX, another master requests, and busy=0 and owner m_as_=1, arbiter SHALL rotate per REQ-017 search regardless of owner request.
REQ-022 Ownership SHALL never change while busy=1 or owner m_as_=0.
REQ-023 Shared-bus outputs SHALL be combinational muxes of the current owner's inputs; m_rdy_ per REQ-010.
REQ-024 Simultaneous owner release and new requests from several masters: REQ-017 priority order applies; released owner is searched last.

Reset
REQ-025 On reset: owner=0, m_grnt_=4'b1110, busy=0, hold counter=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer; m_rdy_ to former owner 1 from the cycle after reset.

Structure
REQ-027 Master count (4), master index constants, and active-low ENABLE_/DISABLE_ levels SHALL come from the shared bus header package.
REQ-028 One sub-module, bus_arbiter_rr, SHALL implement the combinational round-robin next-owner search (inputs: owner, request vector; outputs: next owner, hit).
REQ-029 Owner mux and tracker stay in bus_arbiter; estimated 150-250 lines total.

Verification
REQ-030 Reset, no requests -> m_grnt_=1110 held indefinitely; s_addr equals m_addr[m0].
REQ-031 Owner 0 releases, m_req_=1001 (m1, m2 request) -> next cycle m_grnt_=1101 (m1).
REQ-032 Owner 3 releases with m0 and m2 requesting -> m0 granted (wrap-around 3->0).
REQ-033 HOLD_MAX=4, m0 holds request, m2 requests, no as_ -> owner changes to 2 on fifth cycle after m0 grant; hold counter reads 0.
REQ-034 As REQ-033 but m0 asserts as_ at counter=3, s_rdy_ returned 3 cycles later -> no grant change until cycle after s_rdy_=0.
REQ-035 Reset asserted while busy=1 with owner 2 -> next cycle m_grnt_=1110, m_rdy_=1111, busy=0.
